// File: rtl/obj_scheduler.sv
// Purpose : five-slot collectable-object manager; spawns/frees slots and scrolls/animates/retires objects once per frame.
// Latency : request ack one cycle after sampling in IDLE; frame update visible 7 cycles after the vsync fall (5 UPDATE + COMMIT).
// Backpres: requests are level-held until acked; spawn is held off while full, frame work pre-empts requests.
//
// Ports:
//   vclock, reset_n            pixel clock, async active-low reset
//   vsync                      active-low vertical sync (falling edge = frame tick)
//   speed                      pixels scrolled left per frame
//   spawn_req/type/vpos/ack    spawn handshake (ack is a one-cycle pulse)
//   collect_req/slot/ack       slot-free handshake (ack is a one-cycle pulse)
//   p_obj1..p_obj5             committed words {frame[3], id[2], x[11], y[10]}, zero = empty
//   full                       all five working slots are occupied

module obj_scheduler #(
    parameter int unsigned SPAWN_X  = 1009,
    parameter int unsigned MAX_Y    = 752,
    parameter int unsigned ANIM_DIV = 4
) (
    input  logic        vclock,
    input  logic        reset_n,
    input  logic        vsync,
    input  logic [3:0]  speed,
    input  logic        spawn_req,
    input  logic [1:0]  spawn_type,
    input  logic [9:0]  spawn_vpos,
    output logic        spawn_ack,
    input  logic        collect_req,
    input  logic [2:0]  collect_slot,
    output logic        collect_ack,
    output logic [25:0] p_obj1,
    output logic [25:0] p_obj2,
    output logic [25:0] p_obj3,
    output logic [25:0] p_obj4,
    output logic [25:0] p_obj5,
    output logic        full
);

    localparam logic [10:0] SPAWN_X_W = 11'(SPAWN_X);
    localparam logic [9:0]  MAX_Y_W   = 10'(MAX_Y);
    localparam logic [3:0]  DIV_LAST  = 4'(ANIM_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  idx_q;
    logic        tick_pend_q;
    logic        vsync_d_q;
    logic [3:0]  div_q;
    logic        anim_q;
    logic        spawn_ack_q;
    logic        collect_ack_q;
    logic        full_q;
    logic [25:0] w_q [5];
    logic [25:0] p_q [5];

    logic [25:0] w_d [5];
    logic        full_d;
    logic        tick;
    logic        tick_any;
    logic [4:0]  live;
    logic [2:0]  first_empty;
    logic [9:0]  spawn_y;
    logic [25:0] spawn_word;
    logic        do_collect;
    logic        do_spawn;

    // Frame tick on the vsync falling edge; a pending tick counts as present.
    assign tick     = vsync_d_q & ~vsync;
    assign tick_any = tick | tick_pend_q;

    assign spawn_y    = (spawn_vpos > MAX_Y_W) ? MAX_Y_W : spawn_vpos;
    assign spawn_word = {3'd0, spawn_type, SPAWN_X_W, spawn_y};

    // Frame work always wins; otherwise one request per cycle, collect first.
    // The ack register blocks re-acceptance of the still-held request.
    assign do_collect = (state_q == ST_IDLE) && !tick_any && collect_req && !collect_ack_q;
    assign do_spawn   = (state_q == ST_IDLE) && !tick_any && !do_collect &&
                        spawn_req && !spawn_ack_q && !full_q;

    always_comb begin
        live = '0;
        for (int i = 0; i < 5; i++) begin
            live[i] = |w_q[i];
        end
    end

    // Lowest-index empty slot; 7 when none (spawn is gated by full anyway).
    always_comb begin
        first_empty = 3'd7;
        for (int i = 4; i >= 0; i--) begin
            if (!live[i]) begin
                first_empty = 3'(i);
            end
        end
    end

    // Next working array: per-slot frame update, collect clear, spawn write.
    always_comb begin
        full_d = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w_d[i] = w_q[i];
            if ((state_q == ST_UPDATE) && (idx_q == 3'(i)) && live[i]) begin
                if (w_q[i][20:10] < {7'd0, speed}) begin
                    // Would scroll past the left edge: retire.
                    w_d[i] = '0;
                end else begin
                    w_d[i][20:10] = w_q[i][20:10] - {7'd0, speed};
                    if (anim_q) begin
                        w_d[i][25:23] = w_q[i][25:23] + 3'd1;
                    end
                end
            end
            if (do_collect && (collect_slot == 3'(i))) begin
                w_d[i] = '0;
            end
            if (do_spawn && (first_empty == 3'(i))) begin
                w_d[i] = spawn_word;
            end
            full_d = full_d & (|w_d[i]);
        end
    end

    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= 3'd0;
            tick_pend_q   <= 1'b0;
            vsync_d_q     <= 1'b1;
            div_q         <= 4'd0;
            anim_q        <= 1'b0;
            spawn_ack_q   <= 1'b0;
            collect_ack_q <= 1'b0;
            full_q        <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                w_q[i] <= '0;
                p_q[i] <= '0;
            end
        end else begin
            vsync_d_q     <= vsync;
            spawn_ack_q   <= do_spawn;
            collect_ack_q <= do_collect;
            full_q        <= full_d;
            for (int i = 0; i < 5; i++) begin
                w_q[i] <= w_d[i];
            end

            case (state_q)
                ST_IDLE: begin
                    if (tick_any) begin
                        state_q     <= ST_UPDATE;
                        idx_q       <= 3'd0;
                        tick_pend_q <= 1'b0;
                        // Divider advances once per serviced frame; the
                        // wrapping frame carries the animation step.
                        if (div_q >= DIV_LAST) begin
                            div_q  <= 4'd0;
                            anim_q <= 1'b1;
                        end else begin
                            div_q  <= div_q + 4'd1;
                            anim_q <= 1'b0;
                        end
                    end
                end
                ST_UPDATE: begin
                    if (tick) begin
                        tick_pend_q <= 1'b1;
                    end
                    if (idx_q == 3'd4) begin
                        state_q <= ST_COMMIT;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                ST_COMMIT: begin
                    if (tick) begin
                        tick_pend_q <= 1'b1;
                    end
                    for (int i = 0; i < 5; i++) begin
                        p_q[i] <= w_q[i];
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign spawn_ack   = spawn_ack_q;
    assign collect_ack = collect_ack_q;
    assign full        = full_q;
    assign p_obj1      = p_q[0];
    assign p_obj2      = p_q[1];
    assign p_obj3      = p_q[2];
    assign p_obj4      = p_q[3];
    assign p_obj5      = p_q[4];

endmodule

// File: tb/tb_obj_scheduler.sv
// Directed bench for obj_scheduler: spawn/collect handshakes, frame update
// timing, pending ticks, clamping, animation wrap, retirement and reset.
module tb_obj_scheduler;

    logic        vclock = 1'b0;
    logic        reset_n;
    logic        vsync;
    logic [3:0]  speed;
    logic        spawn_req;
    logic [1:0]  spawn_type;
    logic [9:0]  spawn_vpos;
    logic        spawn_ack;
    logic        collect_req;
    logic [2:0]  collect_slot;
    logic        collect_ack;
    logic [25:0] p_obj1, p_obj2, p_obj3, p_obj4, p_obj5;
    logic        full;

    int checks   = 0;
    int failures = 0;

    always #5 vclock = ~vclock;

    obj_scheduler dut (
        .vclock       (vclock),
        .reset_n      (reset_n),
        .vsync        (vsync),
        .speed        (speed),
        .spawn_req    (spawn_req),
        .spawn_type   (spawn_type),
        .spawn_vpos   (spawn_vpos),
        .spawn_ack    (spawn_ack),
        .collect_req  (collect_req),
        .collect_slot (collect_slot),
        .collect_ack  (collect_ack),
        .p_obj1       (p_obj1),
        .p_obj2       (p_obj2),
        .p_obj3       (p_obj3),
        .p_obj4       (p_obj4),
        .p_obj5       (p_obj5),
        .full         (full)
    );

    function automatic logic [25:0] word(input int f, input int t, input int x, input int y);
        return {3'(f), 2'(t), 11'(x), 10'(y)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_objs(input string tag, input logic [25:0] e1, input logic [25:0] e2,
                            input logic [25:0] e3, input logic [25:0] e4, input logic [25:0] e5);
        chk({tag, " p1"}, {6'd0, p_obj1}, {6'd0, e1});
        chk({tag, " p2"}, {6'd0, p_obj2}, {6'd0, e2});
        chk({tag, " p3"}, {6'd0, p_obj3}, {6'd0, e3});
        chk({tag, " p4"}, {6'd0, p_obj4}, {6'd0, e4});
        chk({tag, " p5"}, {6'd0, p_obj5}, {6'd0, e5});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge vclock);
    endtask

    task automatic do_reset();
        @(negedge vclock);
        reset_n     = 1'b0;
        vsync       = 1'b1;
        spawn_req   = 1'b0;
        collect_req = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    // One frame: vsync falls, rises two cycles later, then enough idle
    // cycles for UPDATE + COMMIT to finish.
    task automatic frame_tick();
        @(negedge vclock);
        vsync = 1'b0;
        cyc(2);
        vsync = 1'b1;
        cyc(8);
    endtask

    // Called at a negedge; ack must be visible exactly one cycle later, for one cycle.
    task automatic spawn(input logic [1:0] t, input logic [9:0] v, input string tag);
        spawn_type = t;
        spawn_vpos = v;
        spawn_req  = 1'b1;
        @(negedge vclock);
        chk({tag, " ack"}, {31'd0, spawn_ack}, 32'd1);
        spawn_req = 1'b0;
        @(negedge vclock);
        chk({tag, " ack pulse"}, {31'd0, spawn_ack}, 32'd0);
    endtask

    task automatic collect(input logic [2:0] s, input string tag);
        collect_slot = s;
        collect_req  = 1'b1;
        @(negedge vclock);
        chk({tag, " ack"}, {31'd0, collect_ack}, 32'd1);
        collect_req = 1'b0;
        @(negedge vclock);
        chk({tag, " ack pulse"}, {31'd0, collect_ack}, 32'd0);
    endtask

    initial begin
        int c_first;
        int s_first;
        int seen;

        reset_n      = 1'b0;
        vsync        = 1'b1;
        speed        = 4'd2;
        spawn_req    = 1'b0;
        spawn_type   = 2'd0;
        spawn_vpos   = 10'd0;
        collect_req  = 1'b0;
        collect_slot = 3'd0;

        // ---- Reset state ----
        do_reset();
        chk_objs("reset", 0, 0, 0, 0, 0);
        chk("reset spawn_ack", {31'd0, spawn_ack}, 0);
        chk("reset collect_ack", {31'd0, collect_ack}, 0);
        chk("reset full", {31'd0, full}, 0);

        // ---- Single spawn, exact commit timing ----
        spawn(2'd1, 10'd300, "spawn1");
        chk("spawn not committed", {6'd0, p_obj1}, 0);
        @(negedge vclock);
        vsync = 1'b0;                       // tick at the next posedge (T)
        @(negedge vclock);
        vsync = 1'b1;
        cyc(5);                             // after edge T+5: still old
        chk("commit not early", {6'd0, p_obj1}, 0);
        cyc(1);                             // after edge T+6: committed
        chk_objs("tick1", word(0, 1, 1007, 300), 0, 0, 0, 0);
        chk("tick1 full", {31'd0, full}, 0);
        cyc(3);

        // ---- Second vsync fall during UPDATE is held pending ----
        speed = 4'd4;
        @(negedge vclock);
        vsync = 1'b0;
        @(negedge vclock);
        vsync = 1'b1;
        @(negedge vclock);
        vsync = 1'b0;
        @(negedge vclock);
        vsync = 1'b1;
        cyc(15);
        chk("pending tick x", {6'd0, p_obj1}, {6'd0, word(0, 1, 999, 300)});

        // ---- Collect of out-of-range and empty slots; speed 0 freezes x, 4th frame animates ----
        collect(3'd7, "collect slot7");
        collect(3'd3, "collect empty");
        speed = 4'd0;
        frame_tick();
        chk_objs("speed0 anim", word(1, 1, 999, 300), 0, 0, 0, 0);
        collect(3'd0, "collect slot0");
        chk("collect not direct", {6'd0, p_obj1}, {6'd0, word(1, 1, 999, 300)});
        frame_tick();
        chk("collect committed", {6'd0, p_obj1}, 0);

        // ---- Fill all five slots, sixth spawn held off ----
        do_reset();
        spawn(2'd0, 10'd10, "fill0");
        spawn(2'd1, 10'd20, "fill1");
        spawn(2'd2, 10'd30, "fill2");
        spawn(2'd3, 10'd1000, "fill3");
        spawn(2'd1, 10'd752, "fill4");
        chk("full after five", {31'd0, full}, 1);
        chk("fill not committed", {6'd0, p_obj1}, 0);
        spawn_type = 2'd2;
        spawn_vpos = 10'd40;
        spawn_req  = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge vclock);
            if (spawn_ack) seen = 1;
        end
        chk("sixth spawn held", seen, 0);
        spawn_req = 1'b0;
        frame_tick();
        chk_objs("filled", word(0, 0, 1009, 10), word(0, 1, 1009, 20), word(0, 2, 1009, 30),
                 word(0, 3, 1009, 752), word(0, 1, 1009, 752));

        // ---- Spawn + collect(2) together with a vsync fall ----
        @(negedge vclock);
        spawn_type   = 2'd2;
        spawn_vpos   = 10'd500;
        spawn_req    = 1'b1;
        collect_slot = 3'd2;
        collect_req  = 1'b1;
        vsync        = 1'b0;
        c_first = 0;
        s_first = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge vclock);
            if (k == 1) vsync = 1'b1;
            if (collect_ack && c_first == 0) begin
                c_first     = k;
                collect_req = 1'b0;
            end
            if (spawn_ack && s_first == 0) begin
                s_first   = k;
                spawn_req = 1'b0;
            end
        end
        spawn_req   = 1'b0;
        collect_req = 1'b0;
        chk("combo collect cycle", c_first, 8);
        chk("combo spawn cycle", s_first, 9);
        chk("combo old slot2 shown", {6'd0, p_obj3}, {6'd0, word(0, 2, 1009, 30)});
        chk("combo full", {31'd0, full}, 1);
        frame_tick();
        chk("combo new slot2", {6'd0, p_obj3}, {6'd0, word(0, 2, 1009, 500)});
        chk("combo slot0 kept", {6'd0, p_obj1}, {6'd0, word(0, 0, 1009, 10)});

        // ---- Reset pulsed during UPDATE idx=2 ----
        @(negedge vclock);
        vsync = 1'b0;                       // tick at edge T
        @(negedge vclock);
        vsync = 1'b1;
        cyc(2);                             // after edge T+2: idx = 2
        reset_n = 1'b0;
        #1;
        chk_objs("mid-update reset", 0, 0, 0, 0, 0);
        chk("mid-update reset full", {31'd0, full}, 0);
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        chk_objs("after release", 0, 0, 0, 0, 0);
        spawn(2'd0, 10'd5, "post-reset spawn");
        frame_tick();
        chk_objs("post-reset frame", word(0, 0, 1009, 5), 0, 0, 0, 0);

        // ---- Animation over 36 frames, wrap 7 -> 0 at frame 32; vpos clamp ----
        do_reset();
        speed = 4'd0;
        spawn(2'd2, 10'd1000, "anim spawn");
        for (int k = 1; k <= 36; k++) begin
            frame_tick();
            chk($sformatf("anim frame %0d", k), {29'd0, p_obj1[25:23]}, (k / 4) % 8);
        end
        chk("anim final word", {6'd0, p_obj1}, {6'd0, word(1, 2, 1009, 752)});

        // ---- Scroll to x=9, then 5, 1, retire; full falls ----
        do_reset();
        for (int k = 0; k < 5; k++) spawn(2'd0, 10'(k + 1), "retire fill");
        chk("retire full", {31'd0, full}, 1);
        speed = 4'd15;
        for (int k = 0; k < 66; k++) frame_tick();
        speed = 4'd10;
        frame_tick();
        chk("x=9", {21'd0, p_obj1[20:10]}, 9);
        speed = 4'd4;
        frame_tick();
        chk("x=5", {21'd0, p_obj1[20:10]}, 5);
        chk("x=5 slot5", {21'd0, p_obj5[20:10]}, 5);
        frame_tick();
        chk("x=1", {21'd0, p_obj1[20:10]}, 1);
        chk("x=1 full", {31'd0, full}, 1);
        frame_tick();
        chk_objs("retired", 0, 0, 0, 0, 0);
        chk("retired full", {31'd0, full}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obj_scheduler.md
# obj_scheduler

Slot manager and frame sequencer for the five collectable-object words consumed by the display pipeline (`p_obj1`..`p_obj5`). Accepts spawn and collect requests from game logic, allocates or frees one of five slots, and on every frame boundary scrolls each live object left, advances its animation frame and retires objects that leave the screen. Presents a stable, frame-coherent set of packed object words to the display, which latches them on the next vsync falling edge.

## Interface
- `SPAWN_X`, 1009: horizontal position given to a newly spawned object (1024 − sprite width 15).
- `MAX_Y`, 752: largest allowed vertical position (768 − sprite height 16); spawn positions above this are clamped.
- `ANIM_DIV`, 4: frames between animation-frame increments (range 1..15).

- `vclock`  in  1  65 MHz pixel clock; all logic on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `vsync`  in  1  active-low vertical sync, synchronous to `vclock`.
- `speed`  in  4  pixels scrolled per frame.
- `spawn_req`  in  1  level request; hold until `spawn_ack`.
- `spawn_type`  in  2  identity field of the new object.
- `spawn_vpos`  in  10  vertical position of the new object.
- `spawn_ack`  out  1  one-cycle acceptance pulse.
- `collect_req`  in  1  level request to free a slot; hold until `collect_ack`.
- `collect_slot`  in  3  slot index 0..4 to free.
- `collect_ack`  out  1  one-cycle acceptance pulse.
- `p_obj1`..`p_obj5`  out  26 each  committed object words: [25:23] frame, [22:21] identity, [20:10] x, [9:0] y. All-zero means the slot is empty.
- `full`  out  1  all five working slots occupied.

## Operation
- Working array `w[0..4]` (26 bits each) and committed output registers; `p_objN` = committed `w[N-1]`. A slot is live iff its word is nonzero.
- Frame tick: `tick = vsync_d & ~vsync`, where `vsync_d` is `vsync` delayed one cycle.
- Global animation divider counts ticks 0..`ANIM_DIV`−1; `anim_step` = 1 on the tick where it wraps.
- FSM:
  - IDLE: if a tick (new or pending) is present, go to UPDATE with idx=0; it takes priority over requests, which stay pending. Otherwise service one request per cycle, collect before spawn.
  - UPDATE: one slot per cycle, idx 0→4. For a live slot: if x < `speed`, clear the word (retire). Otherwise x −= `speed`, and if `anim_step` then frame = frame+1 mod 8. Empty slots stay unchanged. After idx=4, go to COMMIT.
  - COMMIT: copy `w[0..4]` into the outputs and return to IDLE.
- A tick arriving outside IDLE sets `tick_pend`. Pending ticks do not accumulate beyond one. `tick_pend` is cleared on entry to UPDATE.
- Spawn accept (IDLE, no tick, `spawn_ack` low, not full): write the lowest-index empty slot with {3'd0, `spawn_type`, `SPAWN_X`, min(`spawn_vpos`, `MAX_Y`)}. If `full`, hold off and do not ack.
- Collect accept (IDLE, no tick, `collect_ack` low): clear `w[collect_slot]`. Ack even if the slot is already empty. `collect_slot` ≥ 5 is acked with no effect.
- `full` = all `w` nonzero, registered alongside `w`.
- Requests and acks never modify the outputs directly. Changes become visible only at COMMIT.

## Timing
- Reset (asynchronous): `w`, outputs, divider, `tick_pend`, `vsync_d` = 0 (`vsync_d` = 1 is also acceptable; choose 1 to avoid a spurious tick); acks = 0; `full` = 0; state = IDLE.
- `vsync` falls at edge T, so the tick is seen at T. UPDATE runs on cycles T+1..T+5, COMMIT on T+6, and new outputs are valid from T+7.
- Request latency: a request sampled in IDLE at cycle C gets its ack high during C+1 only. The request must drop by C+2, or it is treated as a new request.
- Reset mid-UPDATE aborts immediately. All slots are empty after release.
- Speed 0: positions are frozen; animation still advances.

## Test plan
- Reset, then a single spawn (type 1, vpos 300) → ack 1 cycle later; after the next tick, `p_obj1` = {0,1,1009−speed,300} and other slots 0.
- Six back-to-back spawns with no tick → five acks into slots 0..4, `full`=1, sixth request not acked until a collect frees a slot.
- `speed`=4, one object at x=9 → after tick 1 x=5, after tick 2 x=1, after tick 3 the slot reads 0 and `full` falls.
- `ANIM_DIV`=4, object live for 36 ticks → frame field steps every 4th tick, wrapping 7→0 at tick 32.
- `spawn_req` and `collect_req` (slot 2) raised together at the same cycle as a vsync fall → UPDATE/COMMIT run first, then collect is acked, then spawn lands in slot 2.
- `spawn_vpos`=1000 → stored y=752. `reset_n` pulsed low during UPDATE idx=2 → all outputs 0 immediately, FSM in IDLE.
